// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared types and constants for the oversampling UART receiver.
//
// Contents:
//   rx_state_t   - receiver FSM state encoding
//   OSR_DEFAULT  - ticks per bit the receiver is built around (16)
//   SAMPLE_MID   - centre oversample index; bits are voted from
//                  SAMPLE_MID-1, SAMPLE_MID and SAMPLE_MID+1
//   baud_div()   - clock cycles per oversample tick, never below 1
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OSR_DEFAULT = 16;
    localparam int SAMPLE_MID  = 8;

    // Integer divider from system clock to oversample tick.
    // A baud rate too high for the clock clamps to a tick every cycle.
    function automatic int baud_div(input int clk_freq, input int baud, input int osr);
        int d;
        d = clk_freq / (baud * osr);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//
// Free-running divider that produces the oversampling strobe.
// The counter runs 0..DIV-1 and tick is high for the single cycle in
// which the counter sits at DIV-1.
//
// Parameters:
//   DIV   - clock cycles per tick (>= 1)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   tick  out  one-cycle strobe every DIV cycles
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
//
// 16x oversampling UART receiver, 8 data bits, LSB first, idle high,
// one stop bit. The rx pin is double-flopped, the start bit is confirmed
// at its middle, and every data/stop bit is decided by a 3-sample
// majority vote around the bit centre. Completed bytes are offered on a
// valid/ready handshake with a single holding register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   - a parity bit follows the data (PARITY_ODD selects sense),
//               mismatches pulse parity_err and discard the byte
//   undefined - plain 8N1, no parity_err port
//
// Parameters:
//   CLK_FREQ    system clock in Hz
//   BAUD_RATE   serial bit rate
//   OSR         ticks per bit (only 16 is supported)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   rx          in   serial line, asynchronous, idle high
//   rx_data     out  received byte, held while rx_valid is high
//   rx_valid    out  byte available
//   rx_ready    in   consumer takes the byte when rx_valid && rx_ready
//   frame_err   out  one-cycle pulse: stop bit voted 0
//   overrun     out  one-cycle pulse: finished byte dropped, holder full
//   busy        out  receiver is inside a frame
//   parity_err  out  one-cycle pulse: parity mismatch (parity build only)
// ---------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OSR        = OSR_DEFAULT,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int         DIV     = baud_div(CLK_FREQ, BAUD_RATE, OSR);
    localparam logic [3:0] OS_LAST = 4'(OSR_DEFAULT - 1);
    localparam logic [3:0] OS_S7   = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] OS_S8   = 4'(SAMPLE_MID);
    localparam logic [3:0] OS_S9   = 4'(SAMPLE_MID + 1);

    logic       sync1;
    logic       rx_s;
    logic       tick;

    rx_state_t  state;
    rx_state_t  state_next;

    logic [3:0] os_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       samp7;
    logic       samp8;
    logic       maj;

    logic       stop_done;
    logic       frame_bad;
    logic       byte_good;
    logic       par_ok;
    logic       load;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic       par_bad;
`endif

    // Two-flop synchroniser; flops reset to the idle level so a reset
    // release never looks like a start edge by itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Vote of the three centre samples. Samples 7 and 8 are already
    // registered; sample 9 is the live rx_s, so the result is only
    // meaningful on the os_cnt=9 tick.
    assign maj = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the FSM only moves on tick cycles. STOP leaves
    // at sample 9 instead of 15 so a back-to-back start edge that lands
    // slightly early is still caught from IDLE.
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                    end
                end
                START: begin
                    if ((os_cnt == OS_S7) && rx_s) begin
                        state_next = IDLE;
                    end else if (os_cnt == OS_LAST) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if ((os_cnt == OS_LAST) && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_cnt == OS_LAST) begin
                        state_next = STOP;
                    end
                end
`endif
                STOP: begin
                    if (os_cnt == OS_S9) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output / decision logic derived from the current state.
    always_comb begin
        busy      = (state != IDLE);
        stop_done = tick && (state == STOP) && (os_cnt == OS_S9);
`ifdef UART_RX_PARITY_EN
        par_ok    = !par_bad;
`else
        par_ok    = 1'b1;
`endif
        frame_bad = stop_done && !maj;
        byte_good = stop_done && maj && par_ok;
        load      = byte_good && (!rx_valid || rx_ready);
    end

    // Bit-timing datapath. os_cnt restarts on every state change and
    // simply wraps 15->0 between consecutive data bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            samp7   <= 1'b0;
            samp8   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else if (tick) begin
            if ((state == IDLE) || (state_next != state)) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + 4'd1;
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if ((state == DATA) && (os_cnt == OS_LAST)) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (os_cnt == OS_S7) begin
                samp7 <= rx_s;
            end
            if (os_cnt == OS_S8) begin
                samp8 <= rx_s;
            end

            // LSB arrives first, so shifting right leaves bit 0 in shreg[0]
            // after the eighth bit.
            if ((state == DATA) && (os_cnt == OS_S9)) begin
                shreg <= {maj, shreg[7:1]};
            end

`ifdef UART_RX_PARITY_EN
            if ((state == PARITY) && (os_cnt == OS_S9)) begin
                par_bad <= (maj != ((^shreg) ^ PAR_ODD));
            end
`endif
        end
    end

    // Holding register and status pulses. A load may coincide with the
    // consumer taking the previous byte; otherwise a full holder drops
    // the new byte and flags overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= frame_bad;
            overrun    <= byte_good && !load;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_done && par_bad;
`endif
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os
//
// Directed bench for uart_rx_os at CLK_FREQ=1.6 MHz, BAUD_RATE=10 kbit/s,
// giving one tick every 10 clk and one bit every 160 clk. Build with
// +define+UART_RX_PARITY_EN to add the parity frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD_RATE  = 10000;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLK    = 160;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_OFS  = 160;
    localparam int BREAK_CLK  = 3460;
`else
    localparam int FRAME_OFS  = 0;
    localparam int BREAK_CLK  = 3140;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       flip_par;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int valid_cycles = 0;
    int valid_rises = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic prev_valid = 1'b0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OSR        (16),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    // Pulse/handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && !prev_valid) begin
            valid_rises++;
            last_data = rx_data;
            rise_cyc = cyc;
        end
        prev_valid = rx_valid;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cnt++;
`endif
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCounters();
        valid_cycles = 0;
        valid_rises = 0;
        ferr_cnt = 0;
        ovr_cnt = 0;
        perr_cnt = 0;
        last_data = 8'h00;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d required %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        waitClocks(BIT_CLK);
    endtask

    // One frame; glitch_bit selects a data bit whose centre gets a
    // 10-clk inverted pulse, which hits exactly one of the three votes.
    task automatic sendFrame(input logic [7:0] data, input logic stop_bit,
                             input logic flip_par, input int glitch_bit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                rx = data[i];
                waitClocks(95);
                rx = ~data[i];
                waitClocks(10);
                rx = data[i];
                waitClocks(55);
            end else begin
                sendBit(data[i]);
            end
        end
`ifdef UART_RX_PARITY_EN
        sendBit((^data) ^ (PARITY_ODD != 0) ^ flip_par);
`else
        if (flip_par) rx = 1'b1;
`endif
        sendBit(stop_bit);
        rx = 1'b1;
    endtask

    function automatic vec_t mkVec(input logic [7:0] d, input logic sb, input logic fp,
                                   input logic [7:0] ed, input int ev, input int ef, input int ep);
        vec_t v;
        v.data = d;
        v.stop_bit = sb;
        v.flip_par = fp;
        v.exp_data = ed;
        v.exp_valid = ev;
        v.exp_ferr = ef;
        v.exp_perr = ep;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        clearCounters();
        start_cyc = cyc;
        sendFrame(v.data, v.stop_bit, v.flip_par, -1);
        waitClocks(400);
        checkOutput("valid_cycles", valid_cycles, v.exp_valid);
        checkOutput("frame_err_cnt", ferr_cnt, v.exp_ferr);
        checkOutput("overrun_cnt", ovr_cnt, 0);
        checkOutput("busy_after", busy, 0);
`ifdef UART_RX_PARITY_EN
        checkOutput("parity_err_cnt", perr_cnt, v.exp_perr);
`endif
        if (v.exp_valid != 0) begin
            checkOutput("rx_data", last_data, v.exp_data);
            checkRange("latency", rise_cyc - start_cyc, 1541 + FRAME_OFS, 1555 + FRAME_OFS);
        end
    endtask

    initial begin
        vecs.push_back(mkVec(8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0, 0));
        vecs.push_back(mkVec(8'h3C, 1'b0, 1'b0, 8'h00, 0, 1, 0));
        vecs.push_back(mkVec(8'h5A, 1'b1, 1'b0, 8'h5A, 1, 0, 0));
        vecs.push_back(mkVec(8'h00, 1'b1, 1'b0, 8'h00, 1, 0, 0));
        vecs.push_back(mkVec(8'hFF, 1'b1, 1'b0, 8'hFF, 1, 0, 0));
        vecs.push_back(mkVec(8'h80, 1'b1, 1'b0, 8'h80, 1, 0, 0));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mkVec(8'h07, 1'b1, 1'b0, 8'h07, 1, 0, 0));
        vecs.push_back(mkVec(8'h07, 1'b1, 1'b1, 8'h00, 0, 0, 1));
        vecs.push_back(mkVec(8'h3C, 1'b0, 1'b1, 8'h00, 0, 1, 1));
`endif

        // Reset state.
        waitClocks(5);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b1;
        waitClocks(50);

        // Table-driven frames.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Short low pulse: start bit rejected at its middle.
        clearCounters();
        rx = 1'b0;
        waitClocks(20);
        checkOutput("glitch_busy_high", busy, 1);
        waitClocks(20);
        rx = 1'b1;
        waitClocks(200);
        checkOutput("glitch_busy_low", busy, 0);
        checkOutput("glitch_valid", valid_cycles, 0);
        checkOutput("glitch_ferr", ferr_cnt, 0);
        checkOutput("glitch_ovr", ovr_cnt, 0);

        // Overrun: holder full, second byte dropped.
        clearCounters();
        rx_ready = 1'b0;
        sendFrame(8'h11, 1'b1, 1'b0, -1);
        sendFrame(8'h22, 1'b1, 1'b0, -1);
        waitClocks(400);
        checkOutput("ovr_rx_valid", rx_valid, 1);
        checkOutput("ovr_rx_data", rx_data, 8'h11);
        checkOutput("ovr_count", ovr_cnt, 1);
        checkOutput("ovr_rises", valid_rises, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        checkOutput("ovr_handshake_cycle", rx_valid, 1);
        @(negedge clk);
        checkOutput("ovr_valid_dropped", rx_valid, 0);
        checkOutput("ovr_data_kept", rx_data, 8'h11);
        waitClocks(100);

        // One corrupted centre sample in bit 3 is outvoted.
        clearCounters();
        sendFrame(8'h81, 1'b1, 1'b0, 3);
        waitClocks(400);
        checkOutput("vote_valid", valid_cycles, 1);
        checkOutput("vote_data", last_data, 8'h81);
        checkOutput("vote_held", rx_data, 8'h81);

        // Reset mid-frame, then a clean frame.
        clearCounters();
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("midrst_busy_before", busy, 1);
        rx = 1'b1;
        rst = 1'b0;
        waitClocks(3);
        checkOutput("midrst_rx_data", rx_data, 8'h00);
        checkOutput("midrst_rx_valid", rx_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_frame_err", frame_err, 0);
        rst = 1'b1;
        waitClocks(2000);
        checkOutput("midrst_no_spurious", valid_cycles + ferr_cnt, 0);
        sendFrame(8'h42, 1'b1, 1'b0, -1);
        waitClocks(400);
        checkOutput("midrst_next_valid", valid_cycles, 1);
        checkOutput("midrst_next_data", last_data, 8'h42);

        // Break: line held low, one frame_err per frame period, then the
        // release lands inside a START before its mid check.
        clearCounters();
        rx = 1'b0;
        waitClocks(BREAK_CLK);
        rx = 1'b1;
        waitClocks(400);
        checkOutput("break_ferr", ferr_cnt, 2);
        checkOutput("break_valid", valid_cycles, 0);
        checkOutput("break_busy", busy, 0);
        clearCounters();
        sendFrame(8'h96, 1'b1, 1'b0, -1);
        waitClocks(400);
        checkOutput("after_break_data", last_data, 8'h96);
        checkOutput("after_break_valid", valid_cycles, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
